// File: rtl/rx_frame_receiver.sv
// Serial frame receiver: 2-flop synchronizer, start detect, mid-bit sampling, byte delivery with status.
// Optional even-parity bit enabled by defining RX_PARITY_EN.
module rx_frame_receiver #(
  parameter int unsigned CLKS_PER_BIT = 10,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 serial_in,
  input  logic                 data_read,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_ready,
  output logic                 overrun_error,
  output logic                 framing_error,
  output logic                 parity_error
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int unsigned HALF  = CLKS_PER_BIT / 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_d;
  logic                 ready_d, ovr_d, fe_d, pe_d;
  logic                 sync_meta, sync;
  logic                 fall_c;
  logic                 half_strobe_c, bit_strobe_c;

  // Line synchronizer; both stages idle high
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_meta <= 1'b1;
      sync      <= 1'b1;
    end else begin
      sync_meta <= serial_in;
      sync      <= sync_meta;
    end
  end

  // Falling edge seen one stage early so START is entered on the edge sync first shows 0
  assign fall_c        = sync & ~sync_meta;
  assign half_strobe_c = (cnt_q == CNT_W'(HALF - 1));
  assign bit_strobe_c  = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

`ifdef RX_PARITY_EN
  logic par_q, par_d;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      par_q        <= 1'b0;
      parity_error <= 1'b0;
    end else begin
      par_q        <= par_d;
      parity_error <= pe_d;
    end
  end
`else
  assign parity_error = 1'b0;
`endif

  // State, counters and status registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      bit_q         <= '0;
      shift_q       <= '0;
      rx_data       <= '0;
      data_ready    <= 1'b0;
      overrun_error <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_q         <= bit_d;
      shift_q       <= shift_d;
      rx_data       <= rx_data_d;
      data_ready    <= ready_d;
      overrun_error <= ovr_d;
      framing_error <= fe_d;
    end
  end

  // Next-state, sampling and status update
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    bit_d     = bit_q;
    shift_d   = shift_q;
    rx_data_d = rx_data;
    ready_d   = data_ready;
    ovr_d     = overrun_error;
    fe_d      = framing_error;
    pe_d      = parity_error;
`ifdef RX_PARITY_EN
    par_d     = par_q;
`endif

    if (data_read) begin
      ready_d = 1'b0;
      ovr_d   = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (fall_c) begin
          state_d = S_START;
          fe_d    = 1'b0;
          pe_d    = 1'b0;
        end
      end
      S_START: begin
        if (half_strobe_c) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = sync ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (bit_strobe_c) begin
          cnt_d   = '0;
          shift_d = {sync, shift_q[DATA_BITS-1:1]};
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
            bit_d = '0;
`ifdef RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
`ifdef RX_PARITY_EN
      S_PARITY: begin
        if (bit_strobe_c) begin
          cnt_d   = '0;
          par_d   = sync;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (bit_strobe_c) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (!sync) begin
            fe_d = 1'b1;
          end
`ifdef RX_PARITY_EN
          else if (^{shift_q, par_q}) begin
            pe_d = 1'b1;
          end
`endif
          else begin
            // A simultaneous data_read means the old byte was consumed, so no overrun
            rx_data_d = shift_q;
            ready_d   = 1'b1;
            ovr_d     = data_ready & ~data_read;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: doc/rx_frame_receiver.md
# rx_frame_receiver

Serial frame receiver built around bit-period and bit-count timing of the kind the team's flex counters provide. It sits directly downstream of those counters and folds their role in. It watches an idle-high serial line, detects a start bit and samples each bit mid-period. It delivers a parallel byte with data-ready, overrun, framing and (optional) parity status to the host side.

## Interface
- CLKS_PER_BIT, 10, clock cycles per serial bit (≥4; even values required)
- DATA_BITS, 8, data bits per frame, LSB first
- clk  input  1  system clock, all logic on rising edge
- n_rst  input  1  asynchronous, active-low reset
- serial_in  input  1  asynchronous serial line, idle high
- data_read  input  1  host acknowledge: current rx_data consumed
- rx_data  output  DATA_BITS  last good received byte
- data_ready  output  1  rx_data holds an unread byte
- overrun_error  output  1  a byte was overwritten before being read
- framing_error  output  1  last frame had stop bit = 0
- parity_error  output  1  last frame failed even-parity check

## Operation
- serial_in passes through a 2-flop synchronizer (both flops reset to 1); `sync` denotes the second flop's output, and `sync_prev` denotes its value one cycle earlier.
- Sample counter: counts 1..CLKS_PER_BIT with wrap. Its width is $clog2(CLKS_PER_BIT+1). It is cleared on every state entry. Its "rollover" is the sample strobe.
- Bit counter: counts 0..DATA_BITS-1 in DATA.
- States:
  - IDLE: waits for `sync`=0 with `sync_prev`=1, then goes to START and clears framing_error and parity_error.
  - START: waits CLKS_PER_BIT/2 cycles, then samples `sync`. A value of 1 is a false start and returns to IDLE with no output change. A value of 0 goes to DATA.
  - DATA: samples every CLKS_PER_BIT cycles and shifts the sample into the MSB of the shift register (LSB-first on the line). After DATA_BITS samples it goes to PARITY if the macro is defined, otherwise to STOP.
  - PARITY: samples one bit after CLKS_PER_BIT cycles, then goes to STOP.
  - STOP: samples after CLKS_PER_BIT cycles, then returns to IDLE.
- On the STOP sample edge, exactly one of the following applies:
  - Stop bit 0: framing_error <= 1. No load; rx_data and data_ready are unchanged.
  - Stop bit 1, parity bad (macro on): parity_error <= 1. No load.
  - Stop bit 1, frame good: rx_data <= shift register and data_ready <= 1. If data_ready was already 1 and data_read is 0 on this edge, overrun_error <= 1.
- data_read=1 on an edge with no load: clears data_ready and overrun_error.
- data_read=1 on the same edge as a load: the load wins, data_ready stays 1 and overrun_error is not set, because the old byte counts as read.
- framing_error and parity_error are sticky until the next start detection. They are never cleared by data_read.

## Timing
- Reset: state IDLE, all counters 0, shift register 0. rx_data = 0 and data_ready, overrun_error, framing_error, parity_error = 0.
- Reset asserted mid-frame aborts immediately to the reset values above. No partial byte is ever loaded.
- E0 is the edge at which `sync` first shows 0, which is the 2nd clk edge after serial_in falls.
- Sample edges:
  - Mid-start sample: E0 + CLKS_PER_BIT/2.
  - Data bit k: E0 + CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT.
  - Parity bit: E0 + CLKS_PER_BIT/2 + (DATA_BITS+1)·CLKS_PER_BIT.
  - Stop bit: E0 + CLKS_PER_BIT/2 + (DATA_BITS+1+P)·CLKS_PER_BIT, where P = 1 with the parity macro and 0 without.
- Status outputs are registered and valid immediately after the stop-sample edge. With the defaults and no parity, that edge is E0+95.
- IDLE is re-entered on the edge after the stop sample. A new start can be detected one cycle later, so back-to-back frames with no idle bits are supported.
- An ongoing frame ignores line activity except at sample edges.

## Configuration
- RX_PARITY_EN defined: one even-parity bit follows the data bits. The PARITY state exists, a frame is good only if the XOR of the data bits and the parity bit is 0, and parity_error is live.
- RX_PARITY_EN undefined: no PARITY state, frame length is 1+DATA_BITS+1 bits, and parity_error is tied to 0.

## Test plan
- Reset: hold n_rst=0 with serial_in=1, toggling data_read -> all outputs 0 and rx_data=0. Assert n_rst mid-frame -> outputs return to 0 and no data_ready follows.
- Good frame: defaults, send 0xA5 with stop=1 -> data_ready=1 and rx_data=8'hA5 right after E0+95, all errors 0. Pulse data_read for 1 cycle -> data_ready=0 on the next edge.
- Framing error: send 0x3C with stop=0 -> framing_error=1, data_ready=0, rx_data unchanged. A following good frame 0x11 -> framing_error cleared at E0, rx_data=8'h11.
- Overrun: send 0x12 then 0x34 without data_read -> overrun_error=1 and rx_data=8'h34. data_read -> data_ready=0 and overrun_error=0.
- Edge cases:
  - False start: serial_in low for 3 cycles -> return to IDLE, no output changes.
  - data_read asserted on the same edge as a second load -> data_ready stays 1, overrun_error=0.
- Parity with RX_PARITY_EN: 0x07 with parity bit 0 -> parity_error=1 and no load. 0x07 with parity bit 1 -> load, parity_error=0. Without the macro, 0x07 plus stop loads and parity_error stays 0.
